// File: rtl/adder_slice_sched_if.sv
// Request/response/slice bundle for the shared 3-bit adder slice scheduler.
// Slave side is the scheduler; master side is requesters, sink and slice.
interface adder_slice_sched_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 12
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;

  logic [2:0]            slc_a;
  logic [2:0]            slc_b;
  logic                  slc_cin;
  logic [2:0]            slc_sum;
  logic                  slc_cout;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;

  modport slave (
    input  req_valid, req_a, req_b, req_cin,
    input  slc_sum, slc_cout, rsp_ready,
    output req_ready, slc_a, slc_b, slc_cin,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport master (
    output req_valid, req_a, req_b, req_cin,
    output slc_sum, slc_cout, rsp_ready,
    input  req_ready, slc_a, slc_b, slc_cin,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_slice_sched.sv
// Round-robin scheduler feeding WIDTH-bit adds through one 3-bit slice,
// one chunk per cycle with the carry chained in a register.
module adder_slice_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_slice_sched_if.slave  bus
);
  localparam int CHUNKS = WIDTH / 3;
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;

  logic [IDW-1:0]   win;
  logic             win_v;
  int               idx;

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    win   = '0;
    win_v = 1'b0;
    idx   = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      idx = (int'(ptr_q) + j) % NREQ;
      if (bus.req_valid[idx]) begin
        win   = IDW'(idx);
        win_v = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    k_d           = k_q;
    carry_d       = carry_q;
    cout_d        = cout_q;
    a_d           = a_q;
    b_d           = b_q;
    sum_d         = sum_q;
    bus.req_ready = '0;
    bus.slc_a     = '0;
    bus.slc_b     = '0;
    bus.slc_cin   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_v) begin
          bus.req_ready[win] = rst_n;
          a_d     = bus.req_a[int'(win)*WIDTH +: WIDTH];
          b_d     = bus.req_b[int'(win)*WIDTH +: WIDTH];
          carry_d = bus.req_cin[win];
          id_d    = win;
          ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.slc_a   = 3'(a_q >> (3 * int'(k_q)));
        bus.slc_b   = 3'(b_q >> (3 * int'(k_q)));
        bus.slc_cin = carry_q;
        sum_d[3*int'(k_q) +: 3] = bus.slc_sum;
        carry_d = bus.slc_cout;
        if (k_q == CW'(CHUNKS - 1)) begin
          cout_d  = bus.slc_cout;
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;

endmodule

// File: tb/tb_adder_slice_sched.sv
// Bench for adder_slice_sched: directed scenarios plus randomized traffic
// against an arithmetic and round-robin reference model.
module tb_adder_slice_sched;
  localparam int NREQ   = 2;
  localparam int WIDTH  = 12;
  localparam int CHUNKS = WIDTH / 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_slice_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  adder_slice_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign {bus.slc_cout, bus.slc_sum} =
    {1'b0, bus.slc_a} + {1'b0, bus.slc_b} + {3'b0, bus.slc_cin};

  int checks = 0;
  int failures = 0;
  int exp_ptr = 0;

  function automatic int pick(logic [NREQ-1:0] v, int p);
    for (int j = 0; j < NREQ; j++)
      if (v[(p + j) % NREQ]) return (p + j) % NREQ;
    return -1;
  endfunction

  function automatic logic [WIDTH:0] ref_add(logic [WIDTH-1:0] a,
                                             logic [WIDTH-1:0] b,
                                             logic c);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  task automatic set_op(input int i, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic c);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_cin[i] = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0;
  endtask

  // Waits for rsp_valid; drops requests and scrambles operands after accept.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        bus.req_valid = '0;
        bus.req_a = {$urandom, $urandom};
        bus.req_b = {$urandom, $urandom};
        bus.req_cin = NREQ'($urandom);
      end
      lat++;
    end while (!bus.rsp_valid && lat < 30);
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    bus.req_a = '1;
    bus.req_b = '1;
    bus.req_cin = '1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_sum !== '0) begin
      failures++;
      $display("FAIL reset_rsp_sum got=%h exp=0", bus.rsp_sum);
    end
    checks++;
    if ({bus.rsp_cout, bus.rsp_id} !== '0) begin
      failures++;
      $display("FAIL reset_cout_id got=%b%b exp=0", bus.rsp_cout, bus.rsp_id);
    end
    checks++;
    if (bus.req_ready !== '0) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready);
    end
    checks++;
    if ({bus.slc_a, bus.slc_b, bus.slc_cin} !== '0) begin
      failures++;
      $display("FAIL reset_slc got=%h/%h/%b exp=0", bus.slc_a, bus.slc_b,
               bus.slc_cin);
    end
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    set_op(0, 12'hFFF, 12'h001, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_grant got=%b exp=01", bus.req_ready);
    end
    exp_ptr = 1;
    wait_rsp(lat);
    checks++;
    if (lat != CHUNKS + 1) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=%0d", lat, CHUNKS + 1);
    end
    checks++;
    if ({bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {1'b0, 1'b1, 12'h000}) begin
      failures++;
      $display("FAIL single_result got id=%0d cout=%b sum=%h exp id=0 cout=1 sum=000",
               bus.rsp_id, bus.rsp_cout, bus.rsp_sum);
    end
    release_rsp();
  endtask

  task automatic test_carry_chain();
    set_op(0, 12'h000, 12'hFFF, 1'b1);
    bus.req_valid = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL chain_grant got=%b exp=01", bus.req_ready);
    end
    exp_ptr = 1;
    for (int k = 0; k < CHUNKS; k++) begin
      @(negedge clk);
      bus.req_valid = '0;
      checks++;
      if ({bus.slc_a, bus.slc_b, bus.slc_cin} !== {3'd0, 3'd7, 1'b1}) begin
        failures++;
        $display("FAIL chain_slice_%0d got a=%h b=%h cin=%b exp a=0 b=7 cin=1",
                 k, bus.slc_a, bus.slc_b, bus.slc_cin);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_cout, bus.rsp_sum} !== {1'b1, 1'b1, 12'h000}) begin
      failures++;
      $display("FAIL chain_result got v=%b cout=%b sum=%h exp v=1 cout=1 sum=000",
               bus.rsp_valid, bus.rsp_cout, bus.rsp_sum);
    end
    release_rsp();
  endtask

  task automatic test_round_robin();
    int acc_cyc[$];
    int acc_id[$];
    logic [WIDTH:0] es[NREQ];
    logic [WIDTH-1:0] a, b;
    int cyc;
    int r;
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      set_op(i, a, b, i[0]);
      es[i] = ref_add(a, b, i[0]);
    end
    bus.req_valid = 2'b11;
    cyc = 0;
    r = 0;
    while (acc_id.size() < 4 && cyc < 60) begin
      #1;
      if (bus.req_ready == 2'b01) begin
        acc_id.push_back(0);
        acc_cyc.push_back(cyc);
      end else if (bus.req_ready == 2'b10) begin
        acc_id.push_back(1);
        acc_cyc.push_back(cyc);
      end
      if (bus.rsp_valid) begin
        checks++;
        if ({bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {1'(r % 2), es[r % 2]}) begin
          failures++;
          $display("FAIL rr_rsp_%0d got id=%0d sum=%h exp id=%0d sum=%h",
                   r, bus.rsp_id, {bus.rsp_cout, bus.rsp_sum}, r % 2, es[r % 2]);
        end
        r++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = '0;
    checks++;
    if (acc_id.size() != 4 || r != 3) begin
      failures++;
      $display("FAIL rr_count got grants=%0d rsps=%0d exp 4/3", acc_id.size(), r);
    end
    for (int i = 0; i < acc_id.size(); i++) begin
      checks++;
      if (acc_id[i] != i % 2) begin
        failures++;
        $display("FAIL rr_order_%0d got=%0d exp=%0d", i, acc_id[i], i % 2);
      end
      if (i > 0) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != CHUNKS + 2) begin
          failures++;
          $display("FAIL rr_spacing_%0d got=%0d exp=%0d", i,
                   acc_cyc[i] - acc_cyc[i-1], CHUNKS + 2);
        end
      end
    end
    repeat (CHUNKS + 4) @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [WIDTH:0] e0, e1;
    int c;
    int lat;
    do_reset();
    a0 = WIDTH'($urandom);
    b0 = WIDTH'($urandom);
    a1 = WIDTH'($urandom);
    b1 = WIDTH'($urandom);
    set_op(0, a0, b0, 1'b1);
    set_op(1, a1, b1, 1'b0);
    e0 = ref_add(a0, b0, 1'b1);
    e1 = ref_add(a1, b1, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL bp_grant got=%b exp=01", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 2'b11;
    c = 1;
    while (!bus.rsp_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum, bus.req_ready}
          !== {1'b1, 1'b0, e0, 2'b00}) begin
        failures++;
        $display("FAIL bp_hold_%0d got v=%b id=%0d sum=%h rdy=%b exp v=1 id=0 sum=%h rdy=00",
                 i, bus.rsp_valid, bus.rsp_id, {bus.rsp_cout, bus.rsp_sum},
                 bus.req_ready, e0);
      end
      @(negedge clk);
    end
    release_rsp();
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      failures++;
      $display("FAIL bp_next_grant got=%b exp=10", bus.req_ready);
    end
    wait_rsp(lat);
    checks++;
    if ({bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {1'b1, e1} || lat != CHUNKS + 1) begin
      failures++;
      $display("FAIL bp_next_rsp got id=%0d sum=%h lat=%0d exp id=1 sum=%h lat=%0d",
               bus.rsp_id, {bus.rsp_cout, bus.rsp_sum}, lat, e1, CHUNKS + 1);
    end
    release_rsp();
    exp_ptr = 0;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    do_reset();
    set_op(0, 12'hFFF, 12'hFFF, 1'b0);
    set_op(1, 12'h123, 12'h456, 1'b1);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.slc_a !== 3'd7) begin
      failures++;
      $display("FAIL mid_run_active got slc_a=%h exp=7", bus.slc_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req_ready, bus.slc_a, bus.slc_b, bus.slc_cin,
         bus.rsp_sum, bus.rsp_cout, bus.rsp_id} !== '0) begin
      failures++;
      $display("FAIL mid_run_reset_outs got v=%b rdy=%b slc=%h/%h/%b sum=%h cout=%b id=%0d exp all 0",
               bus.rsp_valid, bus.req_ready, bus.slc_a, bus.slc_b, bus.slc_cin,
               bus.rsp_sum, bus.rsp_cout, bus.rsp_id);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_run_no_rsp got=%b exp=0", bus.rsp_valid);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL mid_run_regrant got=%b exp=01", bus.req_ready);
    end
    exp_ptr = 1;
    wait_rsp(lat);
    checks++;
    if ({bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {1'b0, 13'h1FFE} || lat != CHUNKS + 1) begin
      failures++;
      $display("FAIL mid_run_rsp got id=%0d sum=%h lat=%0d exp id=0 sum=1ffe lat=%0d",
               bus.rsp_id, {bus.rsp_cout, bus.rsp_sum}, lat, CHUNKS + 1);
    end
    release_rsp();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] er;
    logic [WIDTH-1:0] ma[NREQ];
    logic [WIDTH-1:0] mb[NREQ];
    logic mc[NREQ];
    logic [WIDTH:0] e;
    int w;
    int lat;
    for (int it = 0; it < 1000; it++) begin
      v = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        ma[i] = WIDTH'($urandom);
        mb[i] = WIDTH'($urandom);
        mc[i] = 1'($urandom);
        set_op(i, ma[i], mb[i], mc[i]);
      end
      bus.req_valid = v;
      w = pick(v, exp_ptr);
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== er) begin
        failures++;
        $display("FAIL rand_grant_%0d got=%b exp=%b valid=%b", it, bus.req_ready,
                 er, v);
      end
      if (w < 0) begin
        @(negedge clk);
        continue;
      end
      e = ref_add(ma[w], mb[w], mc[w]);
      exp_ptr = (w + 1) % NREQ;
      wait_rsp(lat);
      checks++;
      if (lat != CHUNKS + 1) begin
        failures++;
        $display("FAIL rand_latency_%0d got=%0d exp=%0d", it, lat, CHUNKS + 1);
      end
      checks++;
      if ({bus.rsp_cout, bus.rsp_sum} !== e) begin
        failures++;
        $display("FAIL rand_sum_%0d got=%h exp=%h", it, {bus.rsp_cout, bus.rsp_sum}, e);
      end
      checks++;
      if (int'(bus.rsp_id) != w) begin
        failures++;
        $display("FAIL rand_id_%0d got=%0d exp=%0d", it, bus.rsp_id, w);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_rsp();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_carry_chain();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
